// File: rtl/beat_timing_sequencer_pkg.sv
// Shared types and beat-advance rules for the hardwired controller's timing sequencer.
// Beats and phases are one-hot so each output strobe is a single register bit.
package beat_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    typedef enum logic [2:0] {
        BEAT_W1 = 3'b001,
        BEAT_W2 = 3'b010,
        BEAT_W3 = 3'b100
    } beat_t;

    // PH_NONE is the idle encoding, so all T strobes are low outside RUN.
    typedef enum logic [2:0] {
        PH_NONE = 3'b000,
        PH_T1   = 3'b001,
        PH_T2   = 3'b010,
        PH_T3   = 3'b100
    } phase_t;

    // Beat that follows the current one at the end of its T3 cycle.
    function automatic beat_t beat_advance(beat_t beat, logic short_req, logic long_req);
        beat_t result;
        result = BEAT_W1;
        case (beat)
            BEAT_W1: begin
                if (short_req) result = BEAT_W1;
                else           result = BEAT_W2;
            end
            BEAT_W2: begin
                if (long_req) result = BEAT_W3;
                else          result = BEAT_W1;
            end
            default: result = BEAT_W1;
        endcase
        return result;
    endfunction

    // True when the beat ending now is the last beat of the instruction.
    function automatic logic instr_done(beat_t beat, logic short_req, logic long_req);
        logic result;
        result = 1'b1;
        case (beat)
            BEAT_W1: result = short_req;
            BEAT_W2: result = ~long_req;
            default: result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/beat_timing_sequencer_sync_edge.sv
// Synchronizes the asynchronous start button and emits a registered one-cycle pulse
// on each synchronized rising edge.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   rise_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            // Registered so the controller sees a clean strobe straight from a flop.
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/beat_timing_sequencer.sv
// Beat (W1/W2/W3) and phase (T1/T2/T3) generator for the hardwired CPU controller,
// with stop/single-step halting and a completed-instruction counter.
module beat_timing_sequencer
    import beat_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             qd,
    input  logic             step_mode,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CNT_W-1:0] instr_cnt
);

    seq_state_t       state_reg, state_next;
    phase_t           phase_reg, phase_next;
    beat_t            beat_reg,  beat_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic             start_pulse;
    logic             done;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_qd_sync (
        .clk     (clk),
        .clr     (clr),
        .async_in(qd),
        .rise    (start_pulse)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= IDLE;
            phase_reg <= PH_NONE;
            beat_reg  <= BEAT_W1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            beat_reg  <= beat_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        beat_next  = beat_reg;
        cnt_next   = cnt_reg;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                // The beat is left where it stopped; a restart resumes it from T1.
                phase_next = PH_NONE;
                if (start_pulse) begin
                    state_next = RUN;
                    phase_next = PH_T1;
                end
            end
            RUN: begin
                case (phase_reg)
                    PH_T1: phase_next = PH_T2;
                    PH_T2: phase_next = PH_T3;
                    PH_T3: begin
                        // Controller requests are only meaningful in the last phase of a beat.
                        beat_next = beat_advance(beat_reg, short, long);
                        done      = instr_done(beat_reg, short, long);
                        if (done) begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                        if (stop || (step_mode && done)) begin
                            state_next = IDLE;
                            phase_next = PH_NONE;
                        end else begin
                            phase_next = PH_T1;
                        end
                    end
                    default: phase_next = PH_T1;
                endcase
            end
        endcase
    end

    assign {t3, t2, t1} = phase_reg;
    assign {w3, w2, w1} = beat_reg;
    assign running      = (state_reg == RUN);
    assign instr_cnt    = cnt_reg;

endmodule

// File: tb/tb_beat_timing_sequencer.sv
// Self-checking bench for beat_timing_sequencer: table-driven beat sequences, hand-written
// start/stop/step/reset sequences, then random stimulus against a behavioural model.
module tb_beat_timing_sequencer;

    localparam int S  = 2;
    localparam int CW = 4;
    localparam int N_RANDOM = 3000;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          qd = 1'b0;
    logic          step_mode = 1'b0;
    logic          sh = 1'b0;
    logic          lg = 1'b0;
    logic          sp = 1'b0;
    logic          t1, t2, t3, w1, w2, w3, running;
    logic [CW-1:0] instr_cnt;

    int vectors = 0;
    int miscompares = 0;

    beat_timing_sequencer #(
        .SYNC_STAGES(S),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .qd       (qd),
        .step_mode(step_mode),
        .short    (sh),
        .long     (lg),
        .stop     (sp),
        .t1       (t1),
        .t2       (t2),
        .t3       (t3),
        .w1       (w1),
        .w2       (w2),
        .w3       (w3),
        .running  (running),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       l;
        logic       p;
        logic [2:0] exp_w;
        logic       exp_run;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [2:0] et, input logic [2:0] ew,
                              input logic er, input int ec);
        logic [3+3+1+CW-1:0] got;
        logic [3+3+1+CW-1:0] exp;
        got = {t3, t2, t1, w3, w2, w1, running, instr_cnt};
        exp = {et, ew, er, CW'(ec)};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got t=%b w=%b run=%b cnt=%0d, expected t=%b w=%b run=%b cnt=%0d",
                     name, {t3, t2, t1}, {w3, w2, w1}, running, instr_cnt,
                     et, ew, er, ec % (1 << CW));
        end else begin
            $display("ok   %s: t=%b w=%b run=%b cnt=%0d", name, {t3, t2, t1}, {w3, w2, w1},
                     running, instr_cnt);
        end
    endtask

    // Single press: qd high for one sampled edge; returns just after the edge where T1 appears.
    task automatic press();
        qd = 1'b1;
        tick();
        qd = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] cur_w;
        int         cur_cnt;
        // Behavioural model state (indices, not encodings)
        bit         m_run;
        int         m_ph;
        int         m_beat;
        int         m_cnt;
        bit         m_start;
        bit         m_done;
        bit         qhist[$];
        int         n;

        //             s     l     p     w       run   cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 2};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 4};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 5};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 5};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 5};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 6};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 6};

        // Reset state
        repeat (3) tick();
        expect_out("reset", 3'b000, 3'b001, 1'b0, 0);
        @(negedge clk);
        clr = 1'b1;
        repeat (3) tick();
        expect_out("idle_after_reset", 3'b000, 3'b001, 1'b0, 0);

        // Start latency: first sampled at edge k, T1 after edge k+3; qd stays held
        qd = 1'b1;
        tick();
        tick();
        tick();
        expect_out("latency_k+2_idle", 3'b000, 3'b001, 1'b0, 0);
        tick();
        expect_out("latency_k+3_t1", 3'b001, 3'b001, 1'b1, 0);
        tick();
        expect_out("first_t2", 3'b010, 3'b001, 1'b1, 0);
        tick();
        expect_out("first_t3", 3'b100, 3'b001, 1'b1, 0);
        tick();
        expect_out("w2_t1", 3'b001, 3'b010, 1'b1, 0);

        // Table: each record is one full beat with inputs held through its T3
        cur_w   = 3'b010;
        cur_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            sh = tbl[i].s;
            lg = tbl[i].l;
            sp = tbl[i].p;
            tick();
            expect_out($sformatf("tbl%0d_t2", i), 3'b010, cur_w, 1'b1, cur_cnt);
            tick();
            expect_out($sformatf("tbl%0d_t3", i), 3'b100, cur_w, 1'b1, cur_cnt);
            tick();
            expect_out($sformatf("tbl%0d_end", i), tbl[i].exp_run ? 3'b001 : 3'b000,
                       tbl[i].exp_w, tbl[i].exp_run, tbl[i].exp_cnt);
            cur_w   = tbl[i].exp_w;
            cur_cnt = tbl[i].exp_cnt;
        end
        sh = 1'b0;
        lg = 1'b0;
        sp = 1'b0;

        // Held qd must not restart after the stop
        repeat (6) tick();
        expect_out("held_qd_no_restart", 3'b000, 3'b010, 1'b0, 6);

        // Release and re-press: resumes at W2 with T1
        qd = 1'b0;
        tick();
        tick();
        press();
        expect_out("restart_at_w2", 3'b001, 3'b010, 1'b1, 6);

        // Step mode, long instruction; qd pressed mid-run is ignored
        qd        = 1'b1;
        step_mode = 1'b1;
        lg        = 1'b1;
        tick();
        expect_out("step_w2_t2", 3'b010, 3'b010, 1'b1, 6);
        tick();
        tick();
        expect_out("step_w3_t1", 3'b001, 3'b100, 1'b1, 6);
        lg = 1'b0;
        tick();
        tick();
        expect_out("step_w3_t3", 3'b100, 3'b100, 1'b1, 6);
        tick();
        expect_out("step_halt", 3'b000, 3'b001, 1'b0, 7);
        repeat (5) tick();
        expect_out("step_qd_in_run_ignored", 3'b000, 3'b001, 1'b0, 7);

        // Short instructions in step mode until the 4-bit counter wraps 15 -> 0
        qd = 1'b0;
        tick();
        tick();
        sh = 1'b1;
        for (int i = 0; i < 9; i++) begin
            press();
            expect_out($sformatf("wrap%0d_t1", i), 3'b001, 3'b001, 1'b1, 7 + i);
            tick();
            tick();
            tick();
            expect_out($sformatf("wrap%0d_halt", i), 3'b000, 3'b001, 1'b0, (8 + i) % 16);
        end
        sh        = 1'b0;
        step_mode = 1'b0;

        // Asynchronous reset in the T2 cycle of W2
        press();
        tick();
        tick();
        tick();
        tick();
        expect_out("pre_reset_w2_t2", 3'b010, 3'b010, 1'b1, 0);
        #2;
        clr = 1'b0;
        #1;
        expect_out("async_reset_mid_beat", 3'b000, 3'b001, 1'b0, 0);
        repeat (2) tick();
        @(negedge clk);
        clr = 1'b1;

        // Randomized run against the behavioural model
        m_run  = 1'b0;
        m_ph   = 0;
        m_beat = 0;
        m_cnt  = 0;
        for (int i = 0; i < N_RANDOM; i++) begin
            if ($urandom_range(7) == 0)  qd = ~qd;
            if ($urandom_range(63) == 0) step_mode = ~step_mode;
            sh = ($urandom_range(2) == 0);
            lg = ($urandom_range(2) == 0);
            sp = ($urandom_range(15) == 0);
            tick();

            qhist.push_back(qd);
            n = qhist.size() - 1;
            // A start is a 0->1 change of qd as sampled S+1 and S+2 edges ago
            m_start = (n >= S + 1) && qhist[n-S-1] && !((n >= S + 2) && qhist[n-S-2]);
            if (!m_run) begin
                if (m_start) begin
                    m_run = 1'b1;
                    m_ph  = 0;
                end
            end else if (m_ph < 2) begin
                m_ph++;
            end else begin
                case (m_beat)
                    0: begin m_done = sh;  m_beat = sh ? 0 : 1; end
                    1: begin m_done = !lg; m_beat = lg ? 2 : 0; end
                    default: begin m_done = 1'b1; m_beat = 0; end
                endcase
                if (m_done) m_cnt = (m_cnt + 1) % (1 << CW);
                if (sp || (step_mode && m_done)) m_run = 1'b0;
                else m_ph = 0;
            end

            expect_out($sformatf("rand%0d", i), m_run ? 3'(1 << m_ph) : 3'b000,
                       3'(1 << m_beat), m_run, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
